// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port between NUM_REQ
//   valid/ready requesters. One requester holds the grant at a time; the
//   accepted beat is registered onto fifo_wr_en/fifo_wdata one cycle later.
//   The FIFO is never written while full, and no beat is lost or duplicated.
//
// Optional feature macro: FIFO_ARB_BURST_EN
//   defined   : a grant lasts up to BURST_LEN accepted beats
//   undefined : every accepted beat releases the grant (BURST_LEN ignored)
//
// Ports
//   clk              in   single clock, rising edge
//   rst_n            in   synchronous active-low reset
//   req_valid        in   [NUM_REQ]            requester i has a word
//   req_data         in   [NUM_REQ*DATA_WIDTH] word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready        out  [NUM_REQ]            beat i accepted when valid&ready
//   fifo_full        in   FIFO full
//   fifo_almost_full in   FIFO has exactly one free slot
//   fifo_wr_en       out  registered write strobe
//   fifo_wdata       out  [DATA_WIDTH] registered write data
//   grant_valid      out  a requester holds the grant
//   grant_id         out  [$clog2(NUM_REQ)] granted requester index
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 15) begin : g_param_check
    $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and BURST_LEN 1..15");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic                stall;
  logic                accept;
  logic                rel;
  logic                arb;
  logic                any_valid;
  logic [ID_W-1:0]     arb_pick;
  logic [ID_W-1:0]     arb_start;
  logic [ID_W-1:0]     id_next;
  logic                sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;

  assign grant_valid = (state == GRANT);

  // A write already registered consumes the last free slot, so almost_full
  // only stalls while that write is in flight.
  assign stall = fifo_full | (fifo_almost_full & fifo_wr_en);

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_valid & (grant_id == ID_W'(i)) & ~stall;
    end
  end

  // Mux of the granted requester's valid and data.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept  = grant_valid & sel_valid & ~stall;
  assign id_next = ID_W'((32'(grant_id) + 32'd1) % NUM_REQ);

`ifdef FIFO_ARB_BURST_EN
  logic [3:0] beat_cnt;
  logic       burst_done;

  // The accepted beat that completes the burst releases in the same cycle.
  assign burst_done = (beat_cnt == 4'(BURST_LEN - 1));
  assign rel        = grant_valid & (~sel_valid | (accept & burst_done));
`else
  assign rel        = grant_valid & (~sel_valid | accept);
`endif

  assign arb = ~grant_valid | rel;

  // On a release cycle the scan starts past the releasing id directly, so the
  // new grant lands on the next edge without waiting for rr_ptr to update.
  assign arb_start = grant_valid ? id_next : rr_ptr;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    any_valid = 1'b0;
    arb_pick  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(arb_start) + k) % NUM_REQ;
      if (!any_valid && req_valid[ID_W'(idx)]) begin
        any_valid = 1'b1;
        arb_pick  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      rr_ptr     <= '0;
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_wr_en <= accept;
      if (accept) begin
        fifo_wdata <= sel_data;
      end
      if (rel) begin
        rr_ptr <= id_next;
      end
      if (arb) begin
        if (any_valid) begin
          state    <= GRANT;
          grant_id <= arb_pick;
        end else begin
          state    <= IDLE;
        end
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (arb) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 4'd1;
    end
  end
`endif

endmodule
